// File: rtl/lif_sweep_scheduler.sv
// rtl/lif_sweep_scheduler.sv - time-multiplexed 4-bit LIF neuron sweep with indexed spike events (option: LIF_SCHED_RESET_ON_SPIKE_EN)
module lif_sweep_scheduler #(
    parameter int          N_NEURONS  = 4,
    parameter int          IDX_W      = 2,
    parameter int unsigned THRESHOLD  = 8,
    parameter int          LEAK_SHIFT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*N_NEURONS-1:0] currents,
    output logic                   busy,
    output logic                   done,
    output logic                   spk_valid,
    output logic [IDX_W-1:0]       spk_idx,
    input  logic                   spk_ready,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [3:0]             rd_state
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [3:0]       THR      = 4'(THRESHOLD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [3:0]       mem   [N_NEURONS];
    logic [3:0]       cur_q [N_NEURONS];

    logic [3:0] old_state;
    logic [3:0] upd_state;
    logic [3:0] wr_state;
    logic       fire;
    logic       slot_free;
    logic       commit;
    logic       load_spike;
    logic       latch;
    logic       done_set;

    // Shared update datapath for the neuron currently addressed by idx.
    assign old_state = mem[idx];
    assign fire      = (old_state >= THR);
    assign upd_state = cur_q[idx] + (old_state >> LEAK_SHIFT);

`ifdef LIF_SCHED_RESET_ON_SPIKE_EN
    assign wr_state = fire ? 4'd0 : upd_state;
`else
    assign wr_state = upd_state;
`endif

    // A spike can be placed only if the output slot is empty or draining this cycle.
    assign slot_free  = !spk_valid || spk_ready;
    assign load_spike = commit && fire;
    assign busy       = (state != IDLE);
    assign rd_state   = mem[rd_idx];

    // Next-state logic: a firing neuron that cannot place its spike stalls the sweep.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        commit     = 1'b0;
        latch      = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch      = 1'b1;
                    idx_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!fire || slot_free) begin
                    commit = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = FLUSH;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, sweep index and done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            done  <= done_set;
        end
    end

    // Spike slot: a new load wins over a simultaneous accept, giving back-to-back events.
    always_ff @(posedge clk) begin
        if (!reset) begin
            spk_valid <= 1'b0;
            spk_idx   <= '0;
        end else if (load_spike) begin
            spk_valid <= 1'b1;
            spk_idx   <= idx;
        end else if (spk_valid && spk_ready) begin
            spk_valid <= 1'b0;
        end
    end

    // Membrane register file and latched current vector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem[i]   <= 4'd0;
                cur_q[i] <= 4'd0;
            end
        end else begin
            if (latch) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    cur_q[i] <= currents[4*i +: 4];
                end
            end
            if (commit) begin
                mem[idx] <= wr_state;
            end
        end
    end

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// tb/tb_lif_sweep_scheduler.sv - scoreboard bench for lif_sweep_scheduler
`timescale 1ns/1ps
module tb_lif_sweep_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] currents;
    logic        busy;
    logic        done;
    logic        spk_valid;
    logic [1:0]  spk_idx;
    logic        spk_ready;
    logic [1:0]  rd_idx;
    logic [3:0]  rd_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int exp_spk [$];
    int acc_cyc [$];
    logic [3:0] mm [4];
    int leak_exp [4];

    always #10 clk = ~clk;

    lif_sweep_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .currents  (currents),
        .busy      (busy),
        .done      (done),
        .spk_valid (spk_valid),
        .spk_idx   (spk_idx),
        .spk_ready (spk_ready),
        .rd_idx    (rd_idx),
        .rd_state  (rd_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pop the scoreboard on every accepted spike event.
    always @(negedge clk) begin
        if (reset && spk_valid && spk_ready) begin
            if (exp_spk.size() == 0) check("spk_extra", 1, 0);
            else check("spk_idx", spk_idx, exp_spk.pop_front());
            acc_cyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) mm[i] = 4'd0;
    endfunction

    function automatic void model_sweep(input logic [15:0] cur);
        logic [3:0] old_v;
        logic [3:0] new_v;
        logic       f;
        for (int i = 0; i < 4; i++) begin
            old_v = mm[i];
            f     = (old_v >= 4'd8);
            new_v = 4'(cur[4*i +: 4] + (old_v >> 1));
            if (f) exp_spk.push_back(i);
`ifdef LIF_SCHED_RESET_ON_SPIKE_EN
            mm[i] = f ? 4'd0 : new_v;
`else
            mm[i] = new_v;
`endif
        end
    endfunction

    task automatic check_mem_model(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            check(tag, rd_state, mm[i]);
        end
    endtask

    task automatic check_mem_const(input string tag, input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            check(tag, rd_state, v[4*i +: 4]);
        end
    endtask

    task automatic pulse_start(input logic [15:0] cur);
        currents = cur;
        start    = 1'b1;
        model_sweep(cur);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        bit got;
        got = 0;
        lat = 0;
        while (lat < budget && !got) begin
            @(negedge clk);
            lat++;
            if (done) got = 1;
        end
        if (!got) check("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        exp_spk.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int lat;
        int d0;
        leak_exp = '{4, 2, 1, 0};
        reset     = 1'b0;
        start     = 1'b0;
        currents  = 16'h0;
        spk_ready = 1'b1;
        rd_idx    = 2'd0;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_valid", spk_valid, 0);
        check("rst_done", done, 0);
        check("rst_spk_idx", spk_idx, 0);
        check_mem_const("rst_mem", 16'h0000);

        // Two sweeps with the consumer always ready
        pulse_start(16'hF903);
        wait_done(50, lat);
        check("s2_lat1", lat, 6);
        check_mem_const("s2_sweep1", 16'hF903);
        acc_cyc.delete();
        pulse_start(16'hF903);
        wait_done(50, lat);
        check("s2_lat2", lat, 6);
`ifdef LIF_SCHED_RESET_ON_SPIKE_EN
        check_mem_const("s2_sweep2", 16'h0004);
`else
        check_mem_const("s2_sweep2", 16'h6D04);
`endif
        check_mem_model("s2_model");
        check("s2_nspk", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check("s2_b2b", acc_cyc[1] - acc_cyc[0], 1);
        check("s2_drain", exp_spk.size(), 0);

        // Backpressure during sweep 2
        do_reset();
        pulse_start(16'hF903);
        wait_done(50, lat);
        spk_ready = 1'b0;
        pulse_start(16'hF903);
        repeat (3) @(posedge clk);
        #1;
        rd_idx = 2'd3;
        for (int c = 0; c < 5; c++) begin
            check("s3_valid", spk_valid, 1);
            check("s3_idx", spk_idx, 2);
            check("s3_busy", busy, 1);
            check("s3_mem3", rd_state, 15);
            @(posedge clk); #1;
        end
        spk_ready = 1'b1;
        wait_done(50, lat);
        check("s3_lat", 8 + lat, 11);
        check_mem_model("s3_model");
        check("s3_drain", exp_spk.size(), 0);

        // Leak decay on neuron 0
        do_reset();
        pulse_start(16'h0008);
        wait_done(50, lat);
        rd_idx = 2'd0;
        #1;
        check("s4_preload", rd_state, 8);
        acc_cyc.delete();
        for (int s = 0; s < 4; s++) begin
            pulse_start(16'h0000);
            wait_done(50, lat);
            rd_idx = 2'd0;
            #1;
            check("s4_model", rd_state, mm[0]);
`ifndef LIF_SCHED_RESET_ON_SPIKE_EN
            check("s4_leak", rd_state, leak_exp[s]);
`endif
        end
        check("s4_nspk", acc_cyc.size(), 1);
        check("s4_drain", exp_spk.size(), 0);

        // Start during RUN is ignored
        do_reset();
        d0 = done_cnt;
        pulse_start(16'hF903);
        @(posedge clk); #1;
        currents = 16'h1234;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50, lat);
        check("s5_lat", lat, 4);
        repeat (4) @(posedge clk);
        #1;
        check("s5_done_once", done_cnt - d0, 1);
        check("s5_busy", busy, 0);
        check_mem_model("s5_model");

        // Reset in the middle of a sweep with a spike pending
        do_reset();
        pulse_start(16'h0008);
        wait_done(50, lat);
        spk_ready = 1'b0;
        pulse_start(16'h0000);
        @(posedge clk); #1;
        check("s6_valid_pre", spk_valid, 1);
        check("s6_busy_pre", busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        exp_spk.delete();
        d0 = done_cnt;
        check("s6_busy", busy, 0);
        check("s6_valid", spk_valid, 0);
        check("s6_done", done, 0);
        check_mem_const("s6_mem", 16'h0000);
        repeat (6) @(posedge clk);
        #1;
        check("s6_no_done", done_cnt - d0, 0);
        spk_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
